// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder.
// FSM state encodings, word/lane widths and the wait-counter width.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int OFF_W  = 2;
  localparam int CNT_W  = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_WAIT   = 2'd1;
  localparam state_t S_ACCESS = 2'd2;
  localparam state_t S_RESP   = 2'd3;

endpackage

// File: rtl/dmem_ram_array.sv
// Single-port synchronous RAM, 2**ADDR_WIDTH x 32, per-lane write enables.
// Ports: clk, rd_en, wr_lane[3:0], addr, wdata -> rdata (registered).
module dmem_ram_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [LANES-1:0]      wr_lane,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states.
// Ports: clk, rst (sync, active-low), mem_en/we/addr/wdata/be in;
// mem_rdata, mem_ready, mem_busy, mem_err out.
// Option: DMEM_BYTE_WRITE_EN enables per-lane stores via mem_be.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_be,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    req_we;
  logic                    req_err;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic [WORD_W-1:0]       req_wdata;
  logic [LANES-1:0]        req_be;
  logic                    addr_err;
  logic                    do_access;
  logic                    rd_en;
  logic [LANES-1:0]        lane_we;
  logic [WORD_W-1:0]       ram_q;
  logic                    rdata_zero;

  assign addr_err =
    (mem_addr[OFF_W-1:0] != '0) ||
    ((mem_addr >> (ADDR_WIDTH + OFF_W)) != 32'd0);

  // Gating on rst keeps a reset on the access edge from writing.
  assign do_access = (state == S_ACCESS) && rst && !req_err;
  assign rd_en     = do_access && !req_we;

`ifdef DMEM_BYTE_WRITE_EN
  assign lane_we = (do_access && req_we) ? req_be : '0;
`else
  // Full-word stores: the OR makes mem_be irrelevant.
  assign lane_we = (do_access && req_we) ?
                   (req_be | {LANES{1'b1}}) : '0;
`endif

  always_ff @(posedge clk) begin
    if (state == S_IDLE && mem_en) begin
      req_we    <= mem_we;
      req_err   <= addr_err;
      req_idx   <= mem_addr[ADDR_WIDTH+OFF_W-1:OFF_W];
      req_wdata <= mem_wdata;
      req_be    <= mem_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          if (mem_en) begin
            cnt   <= WAIT_LOAD;
            state <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_ACCESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          mem_ready <= 1'b1;
          mem_err   <= req_err;
          // Stores leave the visible read data untouched.
          if (req_err) begin
            rdata_zero <= 1'b1;
          end else if (!req_we) begin
            rdata_zero <= 1'b0;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The RAM read register has no reset, so mask it until a good load.
  assign mem_rdata = rdata_zero ? '0 : ram_q;
  assign mem_busy  = (state != S_IDLE);

  dmem_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .wr_lane (lane_we),
    .addr    (req_idx),
    .wdata   (req_wdata),
    .rdata   (ram_q)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Defaults: ADDR_WIDTH=10, WAIT_CYCLES=2.
module tb_dmem_responder;

  localparam int AW   = 10;
  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  int lat;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH  (AW),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_busy  (mem_busy),
    .mem_err   (mem_err)
  );

  always @(negedge clk) begin
    if (mem_ready === 1'b1) pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request; returns data, error flag and edges-to-ready.
  // With noise set, a store to 0x20 is held on mem_en for the
  // cycle after acceptance.
  task automatic do_req(input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [3:0] be,
                        input bit noise,
                        output logic [31:0] rdo,
                        output logic ero,
                        output int lato);
    mem_en = 1'b1;
    mem_we = we;
    mem_addr = addr;
    mem_wdata = wd;
    mem_be = be;
    @(posedge clk);
    #1;
    if (noise) begin
      mem_we = 1'b1;
      mem_addr = 32'h20;
      mem_wdata = 32'hCAFEF00D;
      mem_be = 4'hF;
    end else begin
      mem_en = 1'b0;
    end
    lato = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      mem_en = 1'b0;
      if (mem_ready === 1'b1) begin
        lato = n;
        break;
      end
    end
    rdo = mem_rdata;
    ero = mem_err;
    chk("busy_in_ready", 32'(mem_busy), 32'd1);
    @(posedge clk);
    #1;
    chk("ready_width", 32'(mem_ready), 32'd0);
    chk("busy_after", 32'(mem_busy), 32'd0);
    chk("err_after", 32'(mem_err), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    mem_en = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b1;
    p0 = pulses;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_pulses", 32'(pulses - p0), 32'd0);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("st10_lat", 32'(lat), 32'(WAIT + 1));
    chk("st10_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld10_lat", 32'(lat), 32'(WAIT + 1));
    chk("ld10_data", rd, 32'hDEADBEEF);
    chk("ld10_err", 32'(er), 32'd0);

    do_req(1'b1, 32'h20, 32'h13579BDF, 4'hF, 0, rd, er, lat);
    p0 = pulses;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1, rd, er, lat);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_pulses", 32'(pulses - p0), 32'd1);
    chk("busy_ld_data", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld20_data", rd, 32'h13579BDF);

    do_req(1'b0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat);
    chk("mis_lat", 32'(lat), 32'(WAIT + 1));
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_data", rd, 32'd0);

    do_req(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, rd, er, lat);
    do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    chk("oor_word0", rd, 32'hA5A5A5A5);
    chk("oor_word0_err", 32'(er), 32'd0);

    do_req(1'b1, 32'h8, 32'h11223344, 4'hF, 0, rd, er, lat);
    do_req(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
`ifdef DMEM_BYTE_WRITE_EN
    chk("byte_lanes", rd, 32'h11BB33DD);
`else
    chk("byte_lanes", rd, 32'hAABBCCDD);
`endif

    do_req(1'b1, 32'h4, 32'h0, 4'hF, 0, rd, er, lat);
    p0 = pulses;
    mem_en = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h4;
    mem_wdata = 32'h55555555;
    mem_be = 4'hF;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    chk("abort_busy", 32'(mem_busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rst_busy", 32'(mem_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_pulses", 32'(pulses - p0), 32'd0);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
    chk("abort_data", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the CPU datapath's load/store interface. It accepts one request at a time (byte address, write enable, write data) and performs it after a configurable number of wait states. Reads are registered and returned with a one-cycle ready pulse. Sits between the datapath's memory-access outputs and an on-chip word-organised RAM, and replaces the zero-latency behavioural data RAM.

Parameters:
ADDR_WIDTH, 10, word-index width; depth = 2**ADDR_WIDTH 32-bit words.
WAIT_CYCLES, 2, wait states inserted between request acceptance and access (0..15).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-low reset.
mem_en  input  1  request valid; sampled only in IDLE.
mem_we  input  1  1 = store, 0 = load; sampled with mem_en.
mem_addr  input  32  byte address; word index = mem_addr[ADDR_WIDTH+1:2].
mem_wdata  input  32  store data.
mem_be  input  4  byte-lane enables for stores; bit i covers bits [8i+7:8i].
mem_rdata  output  32  load data; valid while mem_ready=1.
mem_ready  output  1  one-cycle completion pulse for loads and stores.
mem_busy  output  1  high from acceptance through the ready cycle.
mem_err  output  1  qualified by mem_ready: request was misaligned or out of range.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE, wait counter 0, mem_rdata=0, mem_ready=0, mem_busy=0, mem_err=0.
- Reset does not clear RAM contents.
- Reset mid-request aborts the request. If reset is asserted at or before the access edge, no write occurs.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: on an edge with mem_en=1, latch addr, we, wdata and be into request registers and set mem_busy=1.
  - If WAIT_CYCLES=0, go to ACCESS.
  - Otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each edge. Go to ACCESS on the edge where the counter is 0.
- ACCESS: on the next edge, perform the operation, set mem_ready=1, and go to RESP.
  - Load: mem_rdata <= RAM[index].
  - Store: write RAM[index]. mem_rdata is unchanged.
- RESP: mem_ready=1 for exactly this cycle. On the next edge: mem_ready=0, mem_busy=0, state IDLE.
- Latency: with acceptance at edge E0, mem_ready is high in the cycle after edge E0+WAIT_CYCLES+1. Minimum issue spacing is WAIT_CYCLES+3 cycles.
- mem_en is ignored in every state other than IDLE; no queueing. The RESP cycle does not accept requests.
- Request inputs may change after acceptance; only the latched copies are used.
- Error: mem_addr[1:0]!=0, or mem_addr[31:ADDR_WIDTH+2]!=0.
  - The request is still accepted and timed normally.
  - At ACCESS: no RAM write, mem_rdata <= 0, mem_err=1 with mem_ready.
- mem_err is 0 in every cycle other than an erroring ready cycle.
- A store followed by a load to the same word returns the new data. The RAM array is read-after-write consistent across requests.

Optional Feature:
DMEM_BYTE_WRITE_EN.
- Defined: stores write only the byte lanes with mem_be[i]=1; untouched lanes keep old data. mem_be=4'b0000 is a legal no-op store that still returns mem_ready.
- Undefined: mem_be is ignored and every store writes all 32 bits. The port remains present.
- Loads always return the full word in both builds.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, RESP);
  - the word/byte width constants (32, 4 lanes, 2-bit byte offset);
  - the counter width constant (4 bits).
- Sub-module dmem_ram_array:
  - single-port synchronous RAM, 2**ADDR_WIDTH x 32;
  - per-lane write enables and a registered read port;
  - no reset on the array.
- The FSM, request registers and error check stay in dmem_responder.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles and release -> mem_ready=0, mem_busy=0, mem_err=0, mem_rdata=0; no ready pulses for 10 idle cycles.
- Store/load round trip (WAIT_CYCLES=2): store 0xDEADBEEF to 0x00000010, then load 0x00000010 -> each ready pulse arrives 4 cycles after acceptance and is 1 cycle wide; load returns 0xDEADBEEF with mem_err=0.
- Ignored request while busy: assert mem_en with a store to 0x20 on the cycle after acceptance of a load from 0x10 -> exactly one ready pulse; a later load from 0x20 returns the prior value.
- Error cases:
  - Load from 0x00000012 -> ready with mem_err=1, mem_rdata=0.
  - Store to 0x00001000 with ADDR_WIDTH=10 -> ready with mem_err=1; RAM unchanged (word 0 still holds its old value).
- Byte lanes: over 0x11223344 at 0x8, store 0xAABBCCDD with mem_be=4'b0101, then load 0x8.
  - With DMEM_BYTE_WRITE_EN: returns 0x11BB33DD.
  - Without it: returns 0xAABBCCDD.
- Reset mid-request: accept a store of 0x55555555 to 0x4 (old value 0x0), assert rst=0 in WAIT, release, then load 0x4 -> returns 0x00000000; no ready pulse is emitted for the aborted store.
